// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler time-shared by NUM_CH periodic tick/square-wave channels with base-tick-aligned config
module tick_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int PER_W    = 16,
  parameter int PRESCALE = 4,
  parameter int PRE_W    = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [2:0]        cfg_ch_i,
  input  logic [PER_W-1:0]  cfg_period_i,
  output logic              cfg_err_o,
  output logic              base_tick_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] sq_o,
  output logic              busy_o
);
  typedef enum logic {IDLE, WAIT_TICK} state_t;
  state_t             state_q;
  logic [PRE_W-1:0]   pre_cnt_q;
  logic               base_tick_q;
  logic               cfg_err_q;
  logic [2:0]         lat_ch_q;
  logic [PER_W-1:0]   lat_per_q;
  logic [PER_W-1:0]   per_q [NUM_CH];
  logic [PER_W-1:0]   per_d [NUM_CH];
  logic [PER_W-1:0]   cnt_q [NUM_CH];
  logic [PER_W-1:0]   cnt_d [NUM_CH];
  logic [NUM_CH-1:0]  tick_q, tick_d, sq_q, sq_d;
  logic               wrap, accept, ch_ok, apply;
  assign wrap        = pre_cnt_q == PRE_W'(PRESCALE - 1);
  assign accept      = state_q == IDLE && cfg_valid_i;
  assign ch_ok       = {1'b0, cfg_ch_i} < 4'(NUM_CH);
  // a wrap on the accept edge itself sees IDLE, so only later wraps apply
  assign apply       = state_q == WAIT_TICK && wrap;
  assign cfg_ready_o = state_q == IDLE;
  assign busy_o      = state_q == WAIT_TICK;
  assign cfg_err_o   = cfg_err_q;
  assign base_tick_o = base_tick_q;
  assign tick_o      = tick_q;
  assign sq_o        = sq_q;
  // prescaler counter and registered wrap pulse
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pre_cnt_q   <= '0;
      base_tick_q <= 1'b0;
    end else begin
      pre_cnt_q   <= wrap ? '0 : pre_cnt_q + PRE_W'(1);
      base_tick_q <= wrap;
    end
  end
  // config FSM: latch a request, hold it until the next base-tick boundary
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      lat_ch_q  <= '0;
      lat_per_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= accept && !ch_ok;
      if (state_q == IDLE) begin
        if (accept && ch_ok) begin
          lat_ch_q  <= cfg_ch_i;
          lat_per_q <= cfg_period_i;
          state_q   <= WAIT_TICK;
        end
      end else if (wrap) begin
        state_q <= IDLE;
      end
    end
  end
  // per-channel next state; a config apply overrides any coincident expiry
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      per_d[c]  = per_q[c];
      cnt_d[c]  = cnt_q[c];
      tick_d[c] = 1'b0;
      sq_d[c]   = sq_q[c];
      if (apply && lat_ch_q == 3'(c)) begin
        per_d[c] = lat_per_q;
        cnt_d[c] = '0;
        sq_d[c]  = 1'b0;
      end else if (per_q[c] == '0) begin
        cnt_d[c] = '0;
        sq_d[c]  = 1'b0;
      end else if (wrap) begin
        tick_d[c] = cnt_q[c] == per_q[c] - PER_W'(1);
        cnt_d[c]  = tick_d[c] ? '0 : cnt_q[c] + PER_W'(1);
        sq_d[c]   = sq_q[c] ^ tick_d[c];
      end
    end
  end
  // channel state registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      per_q  <= '{default: '0};
      cnt_q  <= '{default: '0};
      tick_q <= '0;
      sq_q   <= '0;
    end else begin
      per_q  <= per_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: table vectors, directed corner sequences and random stimulus against a wrap-index model
module tb_tick_scheduler;
  localparam int N = 4;
  localparam int P = 4;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          v = 1'b0;
  logic [2:0]    ch = '0;
  logic [15:0]   per_in = '0;
  logic          cfg_ready_o, cfg_err_o, base_tick_o, busy_o;
  logic [N-1:0]  tick_o, sq_o;
  int total = 0;
  int bad = 0;
  int m_k;
  int m_per [N];
  int m_aw [N];
  bit m_pend, m_acc;
  int m_pch, m_pper;
  logic [N-1:0] e_tick, e_sq;
  logic e_bt, e_err, e_busy, e_ready;
  typedef struct {
    logic [2:0]  ch;
    logic [15:0] per;
    logic        exp_err;
    logic        exp_busy;
  } vec_t;
  vec_t tbl [6];

  tick_scheduler #(.NUM_CH(N), .PER_W(16), .PRESCALE(P), .PRE_W(32)) dut (
    .clk_i(clk), .reset_i(reset), .cfg_valid_i(v), .cfg_ready_o(cfg_ready_o),
    .cfg_ch_i(ch), .cfg_period_i(per_in), .cfg_err_o(cfg_err_o),
    .base_tick_o(base_tick_o), .tick_o(tick_o), .sq_o(sq_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0;
    m_pend = 0;
    m_acc = 0;
    for (int c = 0; c < N; c++) begin
      m_per[c] = 0;
      m_aw[c] = 0;
    end
    e_tick = '0; e_sq = '0; e_bt = 0; e_err = 0; e_busy = 0; e_ready = 1;
  endtask

  // channel c applied at wrap index aw ticks whenever a later wrap index is aw + n*period
  task automatic model_edge();
    bit wr, pb;
    int wl;
    wr = (m_k % P) == P - 1;
    pb = m_pend;
    if (pb && wr) begin
      m_per[m_pch] = m_pper;
      m_aw[m_pch] = m_k / P;
      m_pend = 0;
    end
    m_acc = v && !pb;
    e_err = m_acc && ch >= N;
    if (m_acc && ch < N) begin
      m_pend = 1;
      m_pch = int'(ch);
      m_pper = int'(per_in);
    end
    wl = (m_k + 1) / P - 1;
    for (int c = 0; c < N; c++) begin
      e_tick[c] = wr && m_per[c] != 0 && wl > m_aw[c] && ((wl - m_aw[c]) % m_per[c]) == 0;
      e_sq[c] = m_per[c] != 0 && wl >= m_aw[c] && (((wl - m_aw[c]) / m_per[c]) % 2) == 1;
    end
    e_bt = wr;
    e_busy = m_pend;
    e_ready = !m_pend;
    m_k++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("cycle", {base_tick_o, cfg_err_o, busy_o, cfg_ready_o, tick_o, sq_o},
        {e_bt, e_err, e_busy, e_ready, e_tick, e_sq});
  endtask

  task automatic send(input logic [2:0] c, input logic [15:0] p);
    int n;
    n = 0;
    v = 1; ch = c; per_in = p;
    do begin
      step();
      n++;
    end while (!m_acc && n < 50);
    v = 0;
    chk("accept", m_acc, 1);
  endtask

  task automatic wait_tick(input int c, input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_o[c] && n < bound);
    chk("tick_seen", tick_o[c], 1);
  endtask

  task automatic do_reset();
    #2 reset = 1;
    v = 0;
    #1 chk("async_reset", {base_tick_o, cfg_err_o, busy_o, cfg_ready_o, tick_o, sq_o}, 32'h100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  function automatic bit next_wrap_expires();
    int nw;
    nw = (m_k + 1) / P;
    return m_per[0] != 0 && nw > m_aw[0] && ((nw - m_aw[0]) % m_per[0]) == 0;
  endfunction

  initial begin
    int n, bts;
    logic [N-1:0] seen;
    tbl[0] = '{3'd4, 16'd3, 1'b1, 1'b0};
    tbl[1] = '{3'd7, 16'd1, 1'b1, 1'b0};
    tbl[2] = '{3'd1, 16'd2, 1'b0, 1'b1};
    tbl[3] = '{3'd5, 16'd0, 1'b1, 1'b0};
    tbl[4] = '{3'd2, 16'd0, 1'b0, 1'b1};
    tbl[5] = '{3'd0, 16'd1, 1'b0, 1'b1};
    model_reset();
    @(negedge clk);
    chk("reset_state", {base_tick_o, cfg_err_o, busy_o, cfg_ready_o, tick_o, sq_o}, 32'h100);
    reset = 0;
    // 1: free-running prescaler, no channel activity
    bts = 0; seen = '0;
    repeat (20) begin
      step();
      bts += int'(base_tick_o);
      seen |= tick_o;
    end
    chk("t1_base_ticks", bts, 5);
    chk("t1_no_tick", seen, 0);
    // 2: ch0 period 3
    send(3'd0, 16'd3);
    wait_tick(0, 40, n);
    wait_tick(0, 40, n);
    chk("t2_period", n, 12);
    chk("t2_others", {tick_o[N-1:1], sq_o[N-1:1]}, 0);
    // 3: back-to-back configs, second gated by cfg_ready
    send(3'd1, 16'd1);
    chk("t3_gated", cfg_ready_o, 0);
    send(3'd2, 16'd2);
    repeat (8) step();
    wait_tick(1, 20, n);
    wait_tick(1, 20, n);
    chk("t3_ch1_period", n, 4);
    wait_tick(2, 20, n);
    wait_tick(2, 20, n);
    chk("t3_ch2_period", n, 8);
    wait_tick(0, 30, n);
    wait_tick(0, 30, n);
    chk("t3_ch0_period", n, 12);
    // 4: reprogram ch0 so the apply lands on its expiry wrap
    n = 0;
    while (n < 100 && !(!m_pend && (m_k % P) != P - 1 && next_wrap_expires())) begin
      step();
      n++;
    end
    v = 1; ch = 3'd0; per_in = 16'd5;
    step();
    v = 0;
    chk("t4_accept", m_acc, 1);
    n = 0;
    while (!base_tick_o && n < 10) begin
      step();
      n++;
    end
    chk("t4_apply_wrap", base_tick_o, 1);
    chk("t4_no_tick", tick_o[0], 0);
    chk("t4_sq_clear", sq_o[0], 0);
    chk("t4_idle", busy_o, 0);
    wait_tick(0, 60, n);
    chk("t4_next_tick", n, 20);
    // 5: bad channel, then disable ch0
    v = 1; ch = 3'd6; per_in = 16'd3;
    step();
    v = 0;
    chk("t5_err", cfg_err_o, 1);
    chk("t5_no_busy", busy_o, 0);
    step();
    chk("t5_err_one_cycle", cfg_err_o, 0);
    send(3'd0, 16'd0);
    repeat (5) step();
    seen = '0;
    repeat (24) begin
      step();
      seen[0] |= tick_o[0] | sq_o[0];
    end
    chk("t5_ch0_off", seen[0], 0);
    // 6: reset while a config is pending
    send(3'd3, 16'd2);
    chk("t6_pending", busy_o, 1);
    do_reset();
    seen = '0;
    repeat (40) begin
      step();
      seen |= tick_o;
    end
    chk("t6_no_tick", seen, 0);
    // table vectors
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (m_pend && n < 10) begin
        step();
        n++;
      end
      v = 1; ch = tbl[i].ch; per_in = tbl[i].per;
      step();
      v = 0;
      chk("vec_err", cfg_err_o, tbl[i].exp_err);
      chk("vec_busy", busy_o, tbl[i].exp_busy);
      repeat (6) step();
    end
    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      v = $urandom_range(0, 3) == 0;
      ch = 3'($urandom_range(0, 7));
      per_in = ($urandom_range(0, 15) == 0) ? 16'hffff : 16'($urandom_range(0, 6));
      if (i == 700) do_reset();
      step();
    end
    v = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Owns one shared prescaler counter and time-shares it among NUM_CH independent periodic-enable channels.
- Each channel produces a single-cycle tick and a 50%-duty square wave at a programmable multiple of the prescaled base rate.
- A valid/ready config port reprograms channels, with changes aligned to base-tick boundaries.
- Sits between the fast system clock and the display/timing logic that needs slow enables; the design is clocked from a single clock and uses no derived clocks.

Parameters:
- NUM_CH, 4, number of channels (1..8)
- PER_W, 16, channel period register width
- PRESCALE, 4, system clocks per base tick (>=1)
- PRE_W, 32, prescaler counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  config request
- cfg_ready  out  1  config port can accept
- cfg_ch  in  3  target channel index
- cfg_period  in  PER_W  period in base ticks; 0 = disable
- cfg_err  out  1  one-cycle pulse: request named a nonexistent channel
- base_tick  out  1  one-cycle pulse per prescaler wrap
- tick  out  NUM_CH  per-channel one-cycle enable pulse
- sq  out  NUM_CH  per-channel square wave, toggles on each tick
- busy  out  1  config pending (FSM not IDLE)

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset clears:
  - pre_cnt=0, all periods=0, all channel counters=0.
  - tick=0, sq=0, base_tick=0, cfg_err=0, busy=0.
  - cfg_ready=1, FSM=IDLE.
- Reset asserted mid-operation drops any pending config.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - Internal wrap = (pre_cnt==PRESCALE-1); base_tick output is that condition registered (1-cycle lag).
  - PRESCALE=1: wrap every cycle.
- Channel c is enabled iff period[c]!=0. On a wrap edge with channel enabled:
  - cnt[c]==period[c]-1 -> cnt[c]<=0, tick[c]<=1 for exactly one cycle, sq[c]<=~sq[c].
  - else cnt[c]<=cnt[c]+1.
- Non-wrap edges: cnt, sq unchanged; tick[c]=0.
- Disabled channel: cnt=0, tick=0, sq=0.
- Period 1: tick every base tick, sq toggles every base tick.
- Counters compare at PER_W bits; no overflow is possible since cnt < period.
- Config FSM has two states, IDLE and WAIT_TICK:
  - cfg_ready=(state==IDLE); busy=(state==WAIT_TICK).
  - IDLE, cfg_valid&&cfg_ready at edge A, cfg_ch<NUM_CH: latch ch/period, go to WAIT_TICK.
  - IDLE, cfg_valid&&cfg_ready at edge A, cfg_ch>=NUM_CH: cfg_err=1 for the cycle after A, stay IDLE, no state change.
  - WAIT_TICK: apply at the first wrap edge strictly after A (a wrap at A itself does not count). Apply = period[ch]<=latched, cnt[ch]<=0, sq[ch]<=0, tick[ch] not asserted. Return to IDLE; cfg_ready=1 the cycle after apply.
  - Worst-case latency from accept to apply is PRESCALE cycles.
- Coincident apply and expiry on the same channel: config wins, with no tick and no toggle.
- Other channels evolve normally on the apply edge.
- cfg_valid while cfg_ready=0 is ignored; the requester must hold it.
- Rewriting a channel with its current period still restarts its phase (cnt=0, sq=0).

Test Plan:
1. Reset: assert reset asynchronously between edges -> all outputs 0 immediately and cfg_ready=1. Release, run 20 cycles -> base_tick pulses every 4 clk, tick=0.
2. Program ch0 period=3 (PRESCALE=4) -> apply at the next wrap, then tick[0] every 12 clk and sq[0] period 24 clk. ch1..3 stay 0.
3. Program ch1 period=1 and ch2 period=2 back-to-back, with cfg_ready gating the second -> tick[1] every 4 clk, tick[2] every 8 clk, ch0 phase undisturbed.
4. Reprogram ch0 period=5 timed so apply lands on its expiry wrap -> no tick on that wrap, sq[0]=0, next tick[0] 20 clk later.
5. cfg_ch=6 -> cfg_err high exactly 1 cycle, no busy, all channel outputs unchanged. Then write period=0 to ch0 -> tick[0]=0 and sq[0]=0 thereafter.
6. Accept config, assert reset during WAIT_TICK -> busy=0 and periods=0. After release, no channel ever ticks.
